minmax_tracker: RTL
===================

// Module: minmax_tracker
// PURPOSE
//  Streaming stage downstream of the signed-magnitude compare logic.
//  - Accepts a framed stream of signed W-bit samples over a valid/ready handshake.
//  - Compares each sample against the running maximum and minimum using three-way gt/eq/lt compare results.
//  - At frame end, presents max, min, sample count and the multiplicity of the max on a held result handshake.
// PARAMETERS
//  W   4  sample width, two's complement signed
//  CW  8  width of all frame counters; counters saturate at 2^CW-1
// PORTS
//  clk        in   1   single clock, rising edge
//  rst_n      in   1   reset, asynchronous, active-low
//  in_valid   in   1   sample offered
//  in_ready   out  1   stage can accept; transfer when in_valid&&in_ready
//  in_data    in   W   signed sample
//  in_last    in   1   marks last sample of frame; qualified by transfer
//  res_valid  out  1   frame result held valid
//  res_ready  in   1   result consumed when res_valid&&res_ready
//  res_max    out  W   signed maximum of frame
//  res_min    out  W   signed minimum of frame
//  res_count  out  CW  samples in frame (saturating)
//  res_maxcnt out  CW  samples equal to final max (saturating)
//  thresh     in   W   [MINMAX_TRACKER_THRESH_EN only] signed threshold
//  res_above  out  CW  [MINMAX_TRACKER_THRESH_EN only] samples with sample > thresh
// BEHAVIOUR
//  - FSM states: IDLE (no sample yet), ACCUM (frame open), HOLD (result presented).
//  - in_ready=1 in IDLE/ACCUM, 0 in HOLD. res_valid=1 only in HOLD. Both are decoded from registered state only.
//  - IDLE transfer:
//    - max=min=in_data; count=1; maxcnt=1; above=(in_data>thresh).
//    - Next state is HOLD if in_last, else ACCUM.
//  - ACCUM transfer (compare sample vs max, all signed):
//    - gt: max=sample, maxcnt=1.
//    - eq: maxcnt+1.
//    - lt: max/maxcnt unchanged.
//  - ACCUM transfer, min path: if sample lt min, min=sample; otherwise min unchanged.
//  - ACCUM transfer, counters: count+1; above+1 if sample>thresh.
//  - ACCUM transfer, next state: HOLD if in_last, else stay in ACCUM.
//  - Latency: res_valid rises the cycle after the in_last transfer.
//  - No bubble: the first sample of the next frame is accepted the cycle after the result handshake.
//  - HOLD: all res_* outputs are stable while res_valid && !res_ready.
//  - HOLD exit: on res_ready go to IDLE; the accumulator registers keep their values until the next first sample.
//  - Saturation: count, maxcnt and above stick at 2^CW-1. max/min are unaffected by saturation.
//  - Signed range for W=4 is -8..7: -8 < 7. eq is a bitwise-equal compare.
//  - Reset (any time, including mid-frame or in HOLD):
//    - state=IDLE; the partial frame is discarded with no result.
//    - res_valid=0, in_ready=1, res_max=res_min=0.
//    - res_count=res_maxcnt=res_above=0.
//  - thresh is sampled in the same cycle as each transfer; changes mid-frame apply to later samples only.
// CONFIGURATION
//  MINMAX_TRACKER_THRESH_EN defined:
//    - thresh and res_above ports exist.
//    - A third compare instance and the above counter are built.
//  MINMAX_TRACKER_THRESH_EN undefined:
//    - Those ports, the compare instance and the counter are absent.
//    - All other behaviour is identical.
// STRUCTURE
//  - Shared package minmax_pkg holds:
//    - state typedef (IDLE/ACCUM/HOLD encoding);
//    - the compare result struct {gt,eq,lt};
//    - saturating-increment function sat_inc(CW).
//  - Sub-module signed_cmp3 #(W): combinational signed three-way compare producing one-hot gt/eq/lt.
//    - Instanced for max, min and (optionally) threshold.
//  - Top holds the FSM, accumulator registers and counters.
// TESTING
//  1. Frame 3,-2,7,7,-8(last), res_ready=1 -> max=7, min=-8, count=5, maxcnt=2.
//     res_valid high exactly 1 cycle after last transfer.
//  2. Single-sample frame -5 with last -> max=min=-5, count=1, maxcnt=1. IDLE->HOLD directly.
//  3. HOLD with res_ready=0 for 4 cycles, in_valid=1 -> in_ready=0 and outputs stable throughout.
//     Release res_ready -> next frame accepted the following cycle.
//  4. CW=2, frame of 6 samples all 0 -> count=3, maxcnt=3 (saturated). max=min=0.
//  5. rst_n low mid-frame after 2 samples -> outputs zero immediately (async).
//     New frame 1,2(last) -> max=2, min=1, count=2.
//  6. THRESH_EN, thresh=0, frame -1,0,1,5(last) -> res_above=2. Without macro, the build has no thresh port.

Source files
------------

// File: rtl/minmax_pkg.sv
// Shared types and helpers for the min/max tracker.
// Holds the tracker state encoding, the three-way compare result and the
// saturating increment used by every frame counter.
package minmax_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    typedef struct packed {
        logic gt;
        logic eq;
        logic lt;
    } cmp_t;

    // Adds one unless the value already sits at the all-ones limit for a
    // cw-bit counter; callers cast the result back to their own width.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned cw);
        logic [31:0] limit;
        limit = (cw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << cw) - 32'd1);
        return (value >= limit) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/signed_cmp3.sv
// Combinational signed three-way compare of a_i against b_i.
// Exactly one of gt/eq/lt is set; eq is a plain bitwise equality.
module signed_cmp3
    import minmax_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output cmp_t         cmp_o
);

    // Derive lt from the other two so the result is one-hot by construction.
    always_comb begin
        cmp_o    = '0;
        cmp_o.eq = (a_i == b_i);
        cmp_o.gt = ($signed(a_i) > $signed(b_i));
        cmp_o.lt = !cmp_o.eq && !cmp_o.gt;
    end

endmodule

// File: rtl/minmax_tracker.sv
// Framed signed min/max tracker with a held result handshake.
// Optional feature: define MINMAX_TRACKER_THRESH_EN to add the thresh input,
// the res_above output and the count of samples strictly above thresh.
module minmax_tracker
    import minmax_pkg::*;
#(
    parameter int W  = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic          in_last,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [W-1:0]  res_max,
    output logic [W-1:0]  res_min,
    output logic [CW-1:0] res_count,
    output logic [CW-1:0] res_maxcnt
`ifdef MINMAX_TRACKER_THRESH_EN
    ,
    input  logic [W-1:0]  thresh,
    output logic [CW-1:0] res_above
`endif
);

    state_t        state_q, state_d;
    logic [W-1:0]  maxVal_q, maxVal_d;
    logic [W-1:0]  minVal_q, minVal_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] maxCnt_q, maxCnt_d;
    logic          xfer;
    cmp_t          maxCmp;
    cmp_t          minCmp;
    logic          unusedCmpBits;

    signed_cmp3 #(.W(W)) maxCmpInst (
        .a_i   (in_data),
        .b_i   (maxVal_q),
        .cmp_o (maxCmp)
    );

    signed_cmp3 #(.W(W)) minCmpInst (
        .a_i   (in_data),
        .b_i   (minVal_q),
        .cmp_o (minCmp)
    );

`ifdef MINMAX_TRACKER_THRESH_EN
    logic [CW-1:0] above_q, above_d;
    cmp_t          thrCmp;

    signed_cmp3 #(.W(W)) thrCmpInst (
        .a_i   (in_data),
        .b_i   (thresh),
        .cmp_o (thrCmp)
    );

    assign res_above     = above_q;
    assign unusedCmpBits = ^{maxCmp.lt, minCmp.gt, minCmp.eq, thrCmp.eq, thrCmp.lt};
`else
    assign unusedCmpBits = ^{maxCmp.lt, minCmp.gt, minCmp.eq};
`endif

    // Handshake flags depend on registered state only, so no input-to-output path exists.
    assign in_ready   = (state_q != HOLD);
    assign res_valid  = (state_q == HOLD);
    assign xfer       = in_valid && in_ready;
    assign res_max    = maxVal_q;
    assign res_min    = minVal_q;
    assign res_count  = count_q;
    assign res_maxcnt = maxCnt_q;

    // Next-state and accumulator update: first sample seeds, later samples fold in.
    always_comb begin
        state_d  = state_q;
        maxVal_d = maxVal_q;
        minVal_d = minVal_q;
        count_d  = count_q;
        maxCnt_d = maxCnt_q;
`ifdef MINMAX_TRACKER_THRESH_EN
        above_d  = above_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    maxVal_d = in_data;
                    minVal_d = in_data;
                    count_d  = CW'(1);
                    maxCnt_d = CW'(1);
`ifdef MINMAX_TRACKER_THRESH_EN
                    above_d  = thrCmp.gt ? CW'(1) : CW'(0);
`endif
                    state_d  = in_last ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (xfer) begin
                    if (maxCmp.gt) begin
                        maxVal_d = in_data;
                        maxCnt_d = CW'(1);
                    end else if (maxCmp.eq) begin
                        maxCnt_d = CW'(sat_inc(32'(maxCnt_q), CW));
                    end
                    if (minCmp.lt) begin
                        minVal_d = in_data;
                    end
                    count_d = CW'(sat_inc(32'(count_q), CW));
`ifdef MINMAX_TRACKER_THRESH_EN
                    if (thrCmp.gt) begin
                        above_d = CW'(sat_inc(32'(above_q), CW));
                    end
`endif
                    state_d = in_last ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and accumulator registers; reset discards any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            maxVal_q <= '0;
            minVal_q <= '0;
            count_q  <= '0;
            maxCnt_q <= '0;
`ifdef MINMAX_TRACKER_THRESH_EN
            above_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            maxVal_q <= maxVal_d;
            minVal_q <= minVal_d;
            count_q  <= count_d;
            maxCnt_q <= maxCnt_d;
`ifdef MINMAX_TRACKER_THRESH_EN
            above_q  <= above_d;
`endif
        end
    end

endmodule
